spi_slave_shift_engine: RTL

Synthesisable, parametrised SPI slave serialiser/deserialiser in the pclk domain. It oversamples sclk, cs and mosi0, supports all four CPOL/CPHA modes and MSB- or LSB-first order at run time, and has a configurable word width and chip-select select. It transmits from a one-deep TX holding register with a valid/ready handshake and returns each received word with a single-cycle strobe. It sits between the SPI pins and the slave-side register/FIFO logic.

---
 rtl/spi_slave_shift_engine.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/spi_slave_shift_engine.sv
// rtl/spi_slave_shift_engine.sv - oversampled SPI slave shift engine, all CPOL/CPHA modes.
// Optional frame_err output enabled by SPI_SLAVE_FRAME_ERR_EN.
module spi_slave_shift_engine #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    CS_WIDTH   = 2,
  parameter int                    SLAVE_ID   = 0,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_TX = '0
) (
  input  logic                  pclk,
  input  logic                  areset,
  input  logic                  cfg_cpol,
  input  logic                  cfg_cpha,
  input  logic                  cfg_lsb_first,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  busy,
  input  logic                  sclk,
  input  logic [CS_WIDTH-1:0]   cs,
  input  logic                  mosi0,
`ifdef SPI_SLAVE_FRAME_ERR_EN
  output logic                  frame_err,
`endif
  output logic                  miso0,
  output logic                  miso0_oe
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                  state;
  logic [2:0]              sclk_q, cs_q, mosi_q;
  logic                    cpol_q, cpha_q, lsb_q;
  logic                    hold_full, need_load;
  logic [DATA_WIDTH-1:0]   hold_data, shreg, rx_shreg;
  logic [CW-1:0]           bit_cnt;
  logic                    rise, fall, lead, trail, sample_edge, shift_edge;
  logic                    cs_low, cs_fall, accept, load_now;
  logic [DATA_WIDTH-1:0]   next_word, rx_next;
  logic                    unused_bits;

  function automatic logic out_bit(input logic lsb, input logic [DATA_WIDTH-1:0] w);
    return lsb ? w[0] : w[DATA_WIDTH-1];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_word(input logic lsb,
                                                       input logic [DATA_WIDTH-1:0] w);
    return lsb ? (w >> 1) : (w << 1);
  endfunction

  // [0],[1] are the synchroniser, [2] is the history flop for edge detection
  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      sclk_q <= '0;
      cs_q   <= '1;
      mosi_q <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk};
      cs_q   <= {cs_q[1:0], cs[SLAVE_ID]};
      mosi_q <= {mosi_q[1:0], mosi0};
    end
  end

  assign unused_bits = ^{cs, mosi_q[2]};

  assign rise        = sclk_q[1] & ~sclk_q[2];
  assign fall        = ~sclk_q[1] & sclk_q[2];
  assign lead        = cpol_q ? fall : rise;
  assign trail       = cpol_q ? rise : fall;
  assign sample_edge = cpha_q ? trail : lead;
  assign shift_edge  = cpha_q ? lead : trail;
  assign cs_low      = ~cs_q[1];
  assign cs_fall     = ~cs_q[1] & cs_q[2];

  assign tx_ready  = ~hold_full;
  assign accept    = tx_valid & ~hold_full;
  assign next_word = hold_full ? hold_data : DEFAULT_TX;
  assign load_now  = cs_low & ((state == LOAD) | ((state == SHIFT) & shift_edge & need_load));
  assign rx_next   = lsb_q ? {mosi_q[1], rx_shreg[DATA_WIDTH-1:1]}
                           : {rx_shreg[DATA_WIDTH-2:0], mosi_q[1]};

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else begin
      if (accept) hold_data <= tx_data;
      hold_full <= accept | (hold_full & ~load_now);
    end
  end

  always_ff @(posedge pclk or negedge areset) begin
    if (!areset) begin
      state       <= IDLE;
      cpol_q      <= 1'b0;
      cpha_q      <= 1'b0;
      lsb_q       <= 1'b0;
      shreg       <= '0;
      rx_shreg    <= '0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      busy        <= 1'b0;
      miso0       <= 1'b0;
      miso0_oe    <= 1'b0;
      bit_cnt     <= '0;
      need_load   <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err   <= 1'b0;
`endif
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          busy      <= 1'b0;
          miso0_oe  <= 1'b0;
          bit_cnt   <= '0;
          need_load <= 1'b0;
          if (cs_fall) begin
            cpol_q <= cfg_cpol;
            cpha_q <= cfg_cpha;
            lsb_q  <= cfg_lsb_first;
            busy   <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD, SHIFT: begin
          if (!cs_low) begin
            // partial word is dropped; the holding register survives the abort
            state     <= IDLE;
            busy      <= 1'b0;
            miso0     <= 1'b0;
            miso0_oe  <= 1'b0;
            bit_cnt   <= '0;
            need_load <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
            frame_err <= (bit_cnt != '0);
`endif
          end else begin
            if (load_now) begin
              tx_underrun <= ~hold_full;
              need_load   <= 1'b0;
              // CPHA=1 waits for the first leading edge before presenting bit 0
              if (state == LOAD && cpha_q) begin
                shreg <= next_word;
              end else begin
                miso0 <= out_bit(lsb_q, next_word);
                shreg <= shift_word(lsb_q, next_word);
              end
            end else if (state == SHIFT && shift_edge) begin
              miso0 <= out_bit(lsb_q, shreg);
              shreg <= shift_word(lsb_q, shreg);
            end
            if (state == LOAD) begin
              miso0_oe <= 1'b1;
              state    <= SHIFT;
            end
            if (state == SHIFT && sample_edge) begin
              rx_shreg <= rx_next;
              if (bit_cnt == LAST) begin
                bit_cnt   <= '0;
                rx_data   <= rx_next;
                rx_valid  <= 1'b1;
                need_load <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + CW'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
